// File: rtl/demux1_2_buf.sv
// rtl/demux1_2_buf.sv - buffered 1-to-2 stream demultiplexer
// One select-tagged input stream fanned out into two independent FIFO-backed channels.
module demux1_2_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   cnt0,
  output logic [$clog2(DEPTH):0]   cnt1
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q [2];
  logic [AW:0]      wr_ptr_d [2];
  logic [AW:0]      rd_ptr_q [2];
  logic [AW:0]      rd_ptr_d [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [WIDTH-1:0] mem_d    [2][DEPTH];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign out_ready = {out1_ready, out0_ready};

  always_comb begin
    full  = '0;
    empty = '0;
    for (int ch = 0; ch < 2; ch++) begin
      empty[ch] = (wr_ptr_q[ch] == rd_ptr_q[ch]);
      full[ch]  = (wr_ptr_q[ch][AW-1:0] == rd_ptr_q[ch][AW-1:0]) &&
                  (wr_ptr_q[ch][AW] != rd_ptr_q[ch][AW]);
    end
  end

  // No credit for a same-cycle pop: readiness depends only on registered fullness.
  assign in_ready = rst_n && !full[in_sel];

  always_comb begin
    push = '0;
    pop  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      push[ch]     = in_valid && in_ready && (in_sel == 1'(ch));
      pop[ch]      = !empty[ch] && out_ready[ch];
      wr_ptr_d[ch] = wr_ptr_q[ch] + {{AW{1'b0}}, push[ch]};
      rd_ptr_d[ch] = rd_ptr_q[ch] + {{AW{1'b0}}, pop[ch]};
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[ch][i] = mem_q[ch][i];
      end
      if (push[ch]) begin
        mem_d[ch][wr_ptr_q[ch][AW-1:0]] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[ch][i] <= '0;
        end
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[ch][i] <= mem_d[ch][i];
        end
      end
    end
  end

  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data  = mem_q[0][rd_ptr_q[0][AW-1:0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1][AW-1:0]];
  assign cnt0       = wr_ptr_q[0] - rd_ptr_q[0];
  assign cnt1       = wr_ptr_q[1] - rd_ptr_q[1];

endmodule

// File: tb/tb_demux1_2_buf.sv
// tb/tb_demux1_2_buf.sv - self-checking bench for demux1_2_buf
// Vector table plus directed corner sequences and random traffic against a queue model.
module tb_demux1_2_buf;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model: one ordered queue per channel.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       rdy;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [2:0] c0;
    logic [2:0] c1;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  demux1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1, input logic rn);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    rst_n      = rn;
    #1;
  endtask

  function automatic logic exp_ready();
    int n;
    n = in_sel ? q1.size() : q0.size();
    return rst_n && (n < DEPTH);
  endfunction

  task automatic model_check();
    chk("in_ready", in_ready, exp_ready());
    chk("out0_valid", out0_valid, q0.size() != 0);
    chk("out1_valid", out1_valid, q1.size() != 0);
    chk("cnt0", cnt0, q0.size());
    chk("cnt1", cnt1, q1.size());
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
  endtask

  task automatic tick();
    logic acc;
    acc = in_valid && exp_ready();
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_ready && q0.size() != 0) void'(q0.pop_front());
      if (out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // v sel d r0 r1 | rdy v0 d0 v1 d1 c0 c1
    tbl.push_back('{1,0,8'h11,1,1, 1,0,8'h00,0,8'h00,3'd0,3'd0});
    tbl.push_back('{1,1,8'h22,1,1, 1,1,8'h11,0,8'h00,3'd1,3'd0});
    tbl.push_back('{1,0,8'h33,1,1, 1,0,8'h00,1,8'h22,3'd0,3'd1});
    tbl.push_back('{1,1,8'h44,1,1, 1,1,8'h33,0,8'h00,3'd1,3'd0});
    tbl.push_back('{0,0,8'h00,1,1, 1,0,8'h00,1,8'h44,3'd0,3'd1});
    tbl.push_back('{0,0,8'h00,1,1, 1,0,8'h00,0,8'h00,3'd0,3'd0});
    tbl.push_back('{1,0,8'hA0,0,1, 1,0,8'h00,0,8'h00,3'd0,3'd0});
    tbl.push_back('{1,0,8'hA1,0,1, 1,1,8'hA0,0,8'h00,3'd1,3'd0});
    tbl.push_back('{1,0,8'hA2,0,1, 1,1,8'hA0,0,8'h00,3'd2,3'd0});
    tbl.push_back('{1,0,8'hA3,0,1, 1,1,8'hA0,0,8'h00,3'd3,3'd0});
    tbl.push_back('{1,0,8'hA4,0,1, 0,1,8'hA0,0,8'h00,3'd4,3'd0});
    tbl.push_back('{1,1,8'hB0,0,1, 1,1,8'hA0,0,8'h00,3'd4,3'd0});
    tbl.push_back('{0,0,8'h00,0,1, 0,1,8'hA0,1,8'hB0,3'd4,3'd1});
    tbl.push_back('{1,0,8'hA4,1,1, 0,1,8'hA0,0,8'h00,3'd4,3'd0});
    tbl.push_back('{1,0,8'hA4,0,1, 1,1,8'hA1,0,8'h00,3'd3,3'd0});
    tbl.push_back('{0,0,8'h00,0,1, 0,1,8'hA1,0,8'h00,3'd4,3'd0});
    tbl.push_back('{0,1,8'h00,1,1, 1,1,8'hA1,0,8'h00,3'd4,3'd0});
    tbl.push_back('{0,1,8'h00,1,1, 1,1,8'hA2,0,8'h00,3'd3,3'd0});
    tbl.push_back('{0,1,8'h00,1,1, 1,1,8'hA3,0,8'h00,3'd2,3'd0});
    tbl.push_back('{0,1,8'h00,1,1, 1,1,8'hA4,0,8'h00,3'd1,3'd0});
    tbl.push_back('{0,1,8'h00,1,1, 1,0,8'h00,0,8'h00,3'd0,3'd0});

    // Reset held for two cycles with in_valid asserted.
    drive(1, 0, 8'h77, 1, 1, 0);
    chk("rst_in_ready_c0", in_ready, 0);
    tick();
    drive(1, 0, 8'h77, 1, 1, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    tick();
    drive(0, 0, 8'h00, 1, 1, 1);
    chk("post_rst_cnt0", cnt0, 0);
    chk("post_rst_cnt1", cnt1, 0);
    chk("post_rst_in_ready", in_ready, 1);
    model_check();
    tick();

    // Routing, fill/stall and push-while-popping-at-full vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, 1);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_out0_valid", i), out0_valid, tbl[i].v0);
      chk($sformatf("vec%0d_out1_valid", i), out1_valid, tbl[i].v1);
      chk($sformatf("vec%0d_cnt0", i), cnt0, tbl[i].c0);
      chk($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].c1);
      if (tbl[i].v0) chk($sformatf("vec%0d_out0_data", i), out0_data, tbl[i].d0);
      if (tbl[i].v1) chk($sformatf("vec%0d_out1_data", i), out1_data, tbl[i].d1);
      model_check();
      tick();
    end

    // Mid-operation reset with cnt0 = 3 and cnt1 = 2.
    for (int i = 0; i < 5; i++) begin
      drive(1, (i >= 3), 8'(8'hC0 + i), 0, 0, 1);
      model_check();
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    chk("mid_cnt0_pre", cnt0, 3);
    chk("mid_cnt1_pre", cnt1, 2);
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    tick();
    drive(1, 1, 8'h5A, 0, 0, 1);
    chk("mid_out0_valid", out0_valid, 0);
    chk("mid_out1_valid", out1_valid, 0);
    chk("mid_cnt0", cnt0, 0);
    chk("mid_cnt1", cnt1, 0);
    chk("mid_in_ready", in_ready, 1);
    model_check();
    tick();
    drive(0, 0, 8'h00, 0, 1, 1);
    chk("mid_5a_valid", out1_valid, 1);
    chk("mid_5a_data", out1_data, 8'h5A);
    chk("mid_5a_cnt1", cnt1, 1);
    model_check();
    tick();

    // Wrap-around on channel 1 with a random consumer.
    begin
      logic [7:0] rx[$];
      int sent = 0;
      int maxc = 0;
      int cyc  = 0;
      while (rx.size() < 10 && cyc < 200) begin
        logic r;
        r = 1'($urandom % 2);
        drive(sent < 10, 1, 8'(8'h60 + sent), 1, r, 1);
        model_check();
        if (int'(cnt1) > maxc) maxc = int'(cnt1);
        if (out1_valid && r) rx.push_back(out1_data);
        if (sent < 10 && in_ready) sent++;
        tick();
        cyc++;
      end
      chk("wrap_count", rx.size(), 10);
      foreach (rx[i]) chk($sformatf("wrap_order%0d", i), rx[i], 8'(8'h60 + i));
      chk("wrap_max_cnt", (maxc <= DEPTH), 1);
    end

    // Random traffic with occasional resets and biased consumer stalls.
    for (int i = 0; i < 600; i++) begin
      logic r0, r1;
      r0 = (i < 300) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      r1 = (i < 300) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      drive(1'($urandom % 2), 1'($urandom % 2), 8'($urandom), r0, r1,
            ($urandom % 97) != 0);
      model_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
